microcode_bootstrapper: RTL and testbench

Streams microcode bytes from an external byte source into the control-logic microcode SRAM at power-up, then hands the SRAM over to the control logic. It drives the write side of the bootstrap interface that the control logic consumes: `BOOTSTRAP_ADDR`, `BOOTSTRAP_DATA`, `BOOTSTRAP_N_WE` and `N_BOOTED`. It verifies a trailing checksum before releasing `N_BOOTED`, so a corrupt image never reaches the CPU.

---
 rtl/microcode_bootstrapper_if.sv | 21 ++
 rtl/microcode_bootstrapper.sv | 81 ++++++++
 tb/tb_microcode_bootstrapper.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/microcode_bootstrapper_if.sv
// Bootstrap bus: byte-source handshake in, microcode SRAM write side and boot status out.
interface microcode_bootstrapper_if;
    logic [7:0]  IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic [11:0] BOOTSTRAP_ADDR;
    logic [7:0]  BOOTSTRAP_DATA;
    logic        BOOTSTRAP_N_WE;
    logic        N_BOOTED;
    logic        BOOT_ERR;

    modport master (
        input  IN_DATA, IN_VALID,
        output IN_READY, BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE, N_BOOTED, BOOT_ERR
    );

    modport slave (
        output IN_DATA, IN_VALID,
        input  IN_READY, BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE, N_BOOTED, BOOT_ERR
    );
endinterface

// File: rtl/microcode_bootstrapper.sv
// Loads LENGTH microcode bytes into SRAM with a setup/strobe/hold write cycle per byte,
// then verifies a trailing checksum byte before releasing N_BOOTED.
module microcode_bootstrapper #(
    parameter int LENGTH = 4096
) (
    input  logic                      CLK,
    input  logic                      RST,
    microcode_bootstrapper_if.master  bus
);
    typedef enum logic [2:0] {
        S_WAIT, S_SETUP, S_STROBE, S_HOLD, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [11:0] LAST_ADDR = 12'(LENGTH - 1);

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_sum;
    logic        r_n_we;
    logic        r_n_booted;
    logic        r_err;

    logic        w_ready;
    logic        w_xfer;
    logic        w_last;
    logic [7:0]  w_check;

    assign w_ready = ((r_state == S_WAIT) || (r_state == S_CHECK)) && !RST;
    assign w_xfer  = bus.IN_VALID && w_ready;
    assign w_last  = (r_addr == LAST_ADDR);
    assign w_check = r_sum + bus.IN_DATA;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_WAIT:   if (w_xfer) w_next = S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: w_next = S_HOLD;
            S_HOLD:   w_next = w_last ? S_CHECK : S_WAIT;
            S_CHECK:  if (w_xfer) w_next = (w_check == 8'd0) ? S_DONE : S_ERR;
            S_DONE:   w_next = S_DONE;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_WAIT;
        endcase
    end

    // Strobe and status flags are registered off the next state so they never glitch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_WAIT;
            r_addr     <= 12'd0;
            r_data     <= 8'd0;
            r_sum      <= 8'd0;
            r_n_we     <= 1'b1;
            r_n_booted <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_n_we     <= (w_next != S_STROBE);
            r_n_booted <= (w_next != S_DONE);
            r_err      <= r_err | (w_next == S_ERR);
            if ((r_state == S_WAIT) && w_xfer) begin
                r_data <= bus.IN_DATA;
                r_sum  <= r_sum + bus.IN_DATA;
            end
            // The address stops at the last byte; the checksum byte is never written.
            if ((r_state == S_HOLD) && !w_last) begin
                r_addr <= r_addr + 12'd1;
            end
        end
    end

    assign bus.IN_READY       = w_ready;
    assign bus.BOOTSTRAP_ADDR = r_addr;
    assign bus.BOOTSTRAP_DATA = r_data;
    assign bus.BOOTSTRAP_N_WE = r_n_we;
    assign bus.N_BOOTED       = r_n_booted;
    assign bus.BOOT_ERR       = r_err;
endmodule

// File: tb/tb_microcode_bootstrapper.sv
// Bench for microcode_bootstrapper: a 4-byte instance and a full 4096-byte instance
// share one byte source; expected writes and boot status come from a byte-list model.
module tb_microcode_bootstrapper;
    logic       clk;
    logic       drv_rst;
    logic [7:0] drv_data;
    logic       drv_valid;
    bit         sel;
    int         checks;
    int         failures;
    int         cyc;
    logic       rst_q;

    microcode_bootstrapper_if b4();
    microcode_bootstrapper_if bk();

    assign b4.IN_DATA  = drv_data;
    assign b4.IN_VALID = drv_valid;
    assign bk.IN_DATA  = drv_data;
    assign bk.IN_VALID = drv_valid;

    microcode_bootstrapper #(.LENGTH(4))    u_small (.CLK(clk), .RST(drv_rst), .bus(b4));
    microcode_bootstrapper #(.LENGTH(4096)) u_full  (.CLK(clk), .RST(drv_rst), .bus(bk));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= drv_rst;
    end

    // Write monitors: record every strobe and count framing violations
    logic [19:0] wq4[$];
    int          ts4[$];
    logic [19:0] prev4;
    logic        prev_we4 = 1'b1;
    int          stab_err4 = 0;
    logic [19:0] wqk[$];
    logic [19:0] prevk;
    logic        prev_wek = 1'b1;
    int          stab_errk = 0;

    always @(negedge clk) begin
        if (!b4.BOOTSTRAP_N_WE) begin
            wq4.push_back({b4.BOOTSTRAP_ADDR, b4.BOOTSTRAP_DATA});
            ts4.push_back(cyc);
            if (({b4.BOOTSTRAP_ADDR, b4.BOOTSTRAP_DATA} !== prev4) || !b4.N_BOOTED || !prev_we4)
                stab_err4 <= stab_err4 + 1;
        end
        if (!prev_we4 && !rst_q && ({b4.BOOTSTRAP_ADDR, b4.BOOTSTRAP_DATA} !== prev4))
            stab_err4 <= stab_err4 + 1;
        prev4    <= {b4.BOOTSTRAP_ADDR, b4.BOOTSTRAP_DATA};
        prev_we4 <= b4.BOOTSTRAP_N_WE;
    end

    always @(negedge clk) begin
        if (!bk.BOOTSTRAP_N_WE) begin
            wqk.push_back({bk.BOOTSTRAP_ADDR, bk.BOOTSTRAP_DATA});
            if (({bk.BOOTSTRAP_ADDR, bk.BOOTSTRAP_DATA} !== prevk) || !bk.N_BOOTED || !prev_wek)
                stab_errk <= stab_errk + 1;
        end
        if (!prev_wek && !rst_q && ({bk.BOOTSTRAP_ADDR, bk.BOOTSTRAP_DATA} !== prevk))
            stab_errk <= stab_errk + 1;
        prevk    <= {bk.BOOTSTRAP_ADDR, bk.BOOTSTRAP_DATA};
        prev_wek <= bk.BOOTSTRAP_N_WE;
    end

    // Reference model: image bytes land at consecutive addresses from 0
    logic [7:0] exp_img[$];

    function automatic int write_diffs(input bit big);
        int d = 0;
        int n = big ? wqk.size() : wq4.size();
        if (n != exp_img.size()) d++;
        for (int i = 0; i < n && i < exp_img.size(); i++) begin
            logic [19:0] e = {12'(i), exp_img[i]};
            if ((big ? wqk[i] : wq4[i]) !== e) d++;
        end
        return d;
    endfunction

    function automatic bit model_err(input logic [7:0] csum);
        int s = 0;
        foreach (exp_img[i]) s += int'(exp_img[i]);
        return ((s + int'(csum)) % 256) != 0;
    endfunction

    function automatic logic cur_ready();
        return sel ? bk.IN_READY : b4.IN_READY;
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            drv_valid = 1'b0;
            drv_data  = 8'($urandom);
        end
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = b;
        for (int n = 0; n < 64; n++) begin
            #1;
            if (cur_ready()) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%02h ready never observed within 64 cycles", b);
        end
    endtask

    task automatic load_image(input int mode);
        int pat[3] = '{0, 3, 7};
        for (int i = 0; i < exp_img.size(); i++) begin
            int gap = (mode == 0) ? 0 : (mode == 1) ? pat[i % 3] : int'($urandom_range(0, 5));
            send(exp_img[i], gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drv_rst   = 1'b1;
        drv_valid = 1'b0;
        @(negedge clk);
        drv_rst = 1'b0;
        wq4.delete();
        ts4.delete();
        wqk.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        drv_rst   = 1'b1;
        drv_valid = 1'b1;
        #1;
        checks++;
        if (b4.IN_READY !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_during_rst got=%b want=0", b4.IN_READY);
        end
        @(negedge clk);
        checks++;
        if ({b4.BOOTSTRAP_ADDR, b4.BOOTSTRAP_DATA, b4.BOOTSTRAP_N_WE, b4.N_BOOTED, b4.BOOT_ERR}
            !== {12'h000, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_values addr=%h data=%h nwe=%b nb=%b err=%b want 000 00 1 1 0",
                     b4.BOOTSTRAP_ADDR, b4.BOOTSTRAP_DATA, b4.BOOTSTRAP_N_WE, b4.N_BOOTED, b4.BOOT_ERR);
        end
        drv_rst   = 1'b0;
        drv_valid = 1'b0;
        #1;
        checks++;
        if (b4.IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after got=%b want=1", b4.IN_READY);
        end
        wq4.delete();
        ts4.delete();
        wqk.delete();
    endtask

    task automatic test_good_image();
        int spacing_bad = 0;
        sel = 1'b0;
        do_reset();
        exp_img = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_image(0);
        @(negedge clk);
        checks++;
        if (b4.N_BOOTED !== 1'b1) begin
            failures++;
            $display("FAIL good_nbooted_before_csum got=%b want=1", b4.N_BOOTED);
        end
        send(8'h56, 0);
        @(negedge clk);
        checks++;
        if ({b4.N_BOOTED, b4.BOOT_ERR} !== {1'b0, model_err(8'h56)}) begin
            failures++;
            $display("FAIL good_status nb=%b err=%b want nb=0 err=%b", b4.N_BOOTED, b4.BOOT_ERR, model_err(8'h56));
        end
        checks++;
        if (write_diffs(1'b0) !== 0) begin
            failures++;
            $display("FAIL good_writes diffs=%0d count=%0d want diffs=0 count=4", write_diffs(1'b0), wq4.size());
        end
        for (int i = 1; i < ts4.size(); i++) if (ts4[i] - ts4[i-1] != 4) spacing_bad++;
        checks++;
        if (spacing_bad !== 0) begin
            failures++;
            $display("FAIL good_strobe_spacing bad_gaps=%0d want=0", spacing_bad);
        end
    endtask

    task automatic test_after_done();
        int bad = 0;
        int n0 = wq4.size();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drv_valid = 1'b1;
            drv_data  = 8'hFF;
            #1;
            if (b4.IN_READY !== 1'b0 || b4.BOOTSTRAP_N_WE !== 1'b1 || b4.N_BOOTED !== 1'b0
                || b4.BOOTSTRAP_ADDR !== 12'h003) bad++;
        end
        checks++;
        if (bad !== 0 || wq4.size() != n0) begin
            failures++;
            $display("FAIL after_done bad_cycles=%0d extra_writes=%0d want 0 0", bad, wq4.size() - n0);
        end
    endtask

    task automatic test_bad_checksum();
        int n0;
        sel = 1'b0;
        do_reset();
        exp_img = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_image(0);
        send(8'h57, 0);
        @(negedge clk);
        #1;
        checks++;
        if ({b4.BOOT_ERR, b4.N_BOOTED, b4.IN_READY} !== {model_err(8'h57), 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL bad_status err=%b nb=%b rdy=%b want 1 1 0", b4.BOOT_ERR, b4.N_BOOTED, b4.IN_READY);
        end
        n0 = wq4.size();
        repeat (20) begin
            @(negedge clk);
            drv_valid = 1'b1;
            drv_data  = 8'($urandom);
        end
        checks++;
        if (n0 !== 4 || wq4.size() !== 4 || b4.BOOT_ERR !== 1'b1) begin
            failures++;
            $display("FAIL bad_no_more_writes writes=%0d err=%b want 4 1", wq4.size(), b4.BOOT_ERR);
        end
    endtask

    task automatic test_stalls();
        sel = 1'b0;
        do_reset();
        exp_img = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_image(1);
        send(8'h56, 3);
        @(negedge clk);
        drv_valid = 1'b0;
        checks++;
        if (write_diffs(1'b0) !== 0 || b4.N_BOOTED !== 1'b0) begin
            failures++;
            $display("FAIL stall_writes diffs=%0d nb=%b want 0 0", write_diffs(1'b0), b4.N_BOOTED);
        end
        checks++;
        if (stab_err4 !== 0) begin
            failures++;
            $display("FAIL stall_strobe_framing violations=%0d want=0", stab_err4);
        end
    endtask

    task automatic test_reset_mid_write();
        sel = 1'b0;
        do_reset();
        exp_img = '{8'h11, 8'h22, 8'h33, 8'h44};
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        @(negedge clk);
        drv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b4.BOOTSTRAP_N_WE !== 1'b0 || b4.BOOTSTRAP_ADDR !== 12'h002) begin
            failures++;
            $display("FAIL midrst_in_strobe nwe=%b addr=%h want 0 002", b4.BOOTSTRAP_N_WE, b4.BOOTSTRAP_ADDR);
        end
        drv_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({b4.BOOTSTRAP_N_WE, b4.BOOTSTRAP_ADDR, b4.BOOTSTRAP_DATA} !== {1'b1, 12'h000, 8'h00}) begin
            failures++;
            $display("FAIL midrst_values nwe=%b addr=%h data=%h want 1 000 00",
                     b4.BOOTSTRAP_N_WE, b4.BOOTSTRAP_ADDR, b4.BOOTSTRAP_DATA);
        end
        drv_rst = 1'b0;
        wq4.delete();
        ts4.delete();
        load_image(0);
        send(8'h56, 0);
        @(negedge clk);
        drv_valid = 1'b0;
        checks++;
        if (write_diffs(1'b0) !== 0 || b4.N_BOOTED !== 1'b0 || b4.BOOT_ERR !== 1'b0) begin
            failures++;
            $display("FAIL midrst_reload diffs=%0d nb=%b err=%b want 0 0 0",
                     write_diffs(1'b0), b4.N_BOOTED, b4.BOOT_ERR);
        end
    endtask

    task automatic test_random_images();
        sel = 1'b0;
        for (int it = 0; it < 8; it++) begin
            int s = 0;
            logic [7:0] csum;
            bit e;
            do_reset();
            exp_img.delete();
            for (int i = 0; i < 4; i++) exp_img.push_back(8'($urandom));
            foreach (exp_img[i]) s += int'(exp_img[i]);
            csum = 8'((256 - (s % 256)) % 256);
            if ($urandom_range(0, 1) == 1) csum = csum + 8'($urandom_range(1, 255));
            e = model_err(csum);
            load_image(2);
            send(csum, int'($urandom_range(0, 3)));
            @(negedge clk);
            drv_valid = 1'b0;
            checks++;
            if ({b4.BOOT_ERR, b4.N_BOOTED} !== {e, e} || write_diffs(1'b0) !== 0) begin
                failures++;
                $display("FAIL random_image it=%0d err=%b nb=%b diffs=%0d want err=%b nb=%b diffs=0",
                         it, b4.BOOT_ERR, b4.N_BOOTED, write_diffs(1'b0), e, e);
            end
        end
        checks++;
        if (stab_err4 !== 0) begin
            failures++;
            $display("FAIL random_strobe_framing violations=%0d want=0", stab_err4);
        end
    endtask

    task automatic test_full_size();
        sel = 1'b1;
        do_reset();
        exp_img.delete();
        for (int i = 0; i < 4096; i++) exp_img.push_back(8'h01);
        load_image(0);
        send(8'h00, 0);
        @(negedge clk);
        drv_valid = 1'b0;
        checks++;
        if ({bk.N_BOOTED, bk.BOOT_ERR} !== {1'b0, model_err(8'h00)}) begin
            failures++;
            $display("FAIL full_status nb=%b err=%b want 0 0", bk.N_BOOTED, bk.BOOT_ERR);
        end
        checks++;
        if (write_diffs(1'b1) !== 0 || wqk.size() == 0 || wqk[wqk.size()-1][19:8] !== 12'hFFF) begin
            failures++;
            $display("FAIL full_writes diffs=%0d count=%0d want diffs=0 count=4096 last=fff",
                     write_diffs(1'b1), wqk.size());
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bk.BOOTSTRAP_ADDR !== 12'hFFF || stab_errk !== 0) begin
            failures++;
            $display("FAIL full_no_wrap addr=%h framing=%0d want fff 0", bk.BOOTSTRAP_ADDR, stab_errk);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        sel       = 1'b0;
        drv_rst   = 1'b1;
        drv_valid = 1'b0;
        drv_data  = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_good_image();
        test_after_done();
        test_bad_checksum();
        test_stalls();
        test_reset_mid_write();
        test_random_images();
        test_full_size();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
